alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Parametrised, synthesisable control sequencer that drives the datapath's register-transfer strobes for register-to-register ALU instructions. It issues fetch (T0–T2) and execute steps from the datapath's IR. Compared with a fixed six-step bench sequence, it adds:
- a generic register count,
- unary and HI/LO (MUL/DIV) variants,
- a memory-ready stall,
- illegal-opcode trapping.

It sits beside `datapath`, replacing hand-driven control signals.

## Interface
- `NREGS`, default 16: general registers. `REG_W = $clog2(NREGS)`.
- `IR_W`, default 32: IR width.
- `OPC_W`, default 5: opcode field width, located at `ir[IR_W-1 -: OPC_W]`. Then, MSB-first, come `ra`, `rb` and `rc`, each `REG_W` bits wide.
- `clock` input, 1: rising-edge clock.
- `clear` input, 1: reset, asynchronous, active-low.
- `start` input, 1: begin an instruction (level, sampled in IDLE/last step).
- `mem_ready` input, 1: memory data valid on `Mdatain`.
- `ir` input, IR_W: datapath IR contents.
- `reg_in` output, NREGS: one-hot Rin strobes.
- `reg_out` output, NREGS: one-hot Rout strobes.
- `alu_op` output, 14: one-hot, bit order ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT, MUL, DIV, IncPC (bits 0..13).
- Individual strobes, output, 1 each: `PCout`, `PCin`, `MARin`, `MDRin`, `MDRout`, `Read`, `IRin`, `Yin`, `Zin`, `Zlowout`, `Zhighout`, `HIin`, `LOin`.
- `busy` output, 1: high in any state except IDLE/FAULT.
- `done` output, 1: high during the final step of each instruction.
- `illegal` output, 1: high in FAULT.

## Operation
States: IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT. Outputs are Moore, decoded from the state and, from T3 on, from `ir`.

Opcodes: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8, NEG 9, NOT 10, MUL 11, DIV 12. Opcodes of 13 and above are illegal.

Step contents:
- **T0:** `PCout`, `MARin`, `alu_op[IncPC]`, `Zin`.
- **T1:** `Zlowout`, `PCin`, `Read`, `MDRin`. Held while `mem_ready`=0 (reloading PC from an unchanged Z is idempotent). Advance to T2 when `mem_ready`=1.
- **T2:** `MDRout`, `IRin`.
- **T3:** decode `ir`.
  - Illegal opcode → FAULT; T3 asserts no strobes.
  - Binary ops (0–8, 11, 12): `reg_out[rb]`, `Yin`.
  - Unary ops (9, 10): `reg_out[rb]`, op bit, `Zin`.
- **T4:**
  - Binary ops: `reg_out[rc]`, op bit, `Zin`.
  - Unary ops: `Zlowout`, `reg_in[ra]`, `done`.
- **T5:**
  - Ops 0–8: `Zlowout`, `reg_in[ra]`, `done`.
  - MUL/DIV: `Zlowout`, `LOin`.
- **T6** (MUL/DIV only): `Zhighout`, `HIin`, `done`. The `ra` field is ignored.

Transitions:
- IDLE → T0 when `start`=1.
- Last step → T0 if `start`=1, else → IDLE.
- FAULT is sticky until `clear` is asserted.

Invariants:
- At most one `reg_out` bit and at most one bus driver are active in any cycle.
- `reg_in` and `reg_out` are all-zero outside the steps named above.

## Timing
- **Reset:** `clear`=0 forces IDLE immediately, including mid-instruction, and drives every output to 0. The first cycle after release is IDLE.
- **Latency from the `start` sample to `done`** (with `mem_ready` tied high):
  - Unary ops: 5 cycles.
  - Ops 0–8: 6 cycles.
  - MUL/DIV: 7 cycles.
  - Each cycle `mem_ready` is low in T1 adds one cycle.
- **Back-to-back:** with `start` held high, the next T0 immediately follows the `done` cycle, with no bubble.
- **`ir` sampling:** `ir` must be stable from the T2→T3 edge until the instruction ends. The block never latches `ir` itself.
- **`done`** is a one-cycle pulse per instruction. It is never asserted in IDLE or FAULT.

## Test plan
- **AND:** R5=0x34, R6=0x45, R2=0x67, `ir`=0x112B0000, `start` pulse → T0..T5 strobes exactly as specified. `done` in cycle 6; R2 becomes 0x04 (datapath bench).
- **MUL:** `ir` opcode 11, rb=R3 (=0x00010000), rc=R4 (=0x00010000) → `LOin` in T5, `HIin` in T6, `done` in cycle 7. Result LO=0x00000000, HI=0x00000001.
- **NEG:** opcode 9, ra=R1, rb=R7 (=0x00000005) → R1=0xFFFFFFFB; `done` in cycle 5, and `Yin` is never asserted.
- **Memory stall:** `mem_ready` low for 3 cycles in T1 → T1 held for 4 cycles with `Read`/`MDRin` high throughout; `done` in cycle 9 for AND.
- **Illegal opcode:** `ir`=0x78000000 → FAULT after T3, `illegal`=1, `busy`=0, no `reg_in` ever asserted. `start` has no effect until `clear` is pulsed low.
- **Reset mid-instruction:** `clear` driven low during T4 of ADD → all outputs 0 in the same cycle, no `reg_in` pulse, state IDLE. Then exercise `NREGS`=8 (`REG_W`=3) with one-hot index checks.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Control sequencer for register-to-register ALU instructions: fetch (T0-T2) then
// execute steps decoded from the datapath IR, with memory stall and illegal-opcode trap.
module alu_op_sequencer #(
  parameter int NREGS = 16,
  parameter int IR_W  = 32,
  parameter int OPC_W = 5
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [IR_W-1:0]  ir,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic [13:0]      alu_op,
  output logic             PCout,
  output logic             PCin,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             Read,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int REG_W   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int INC_PC  = 13;
  localparam int NUM_OPS = 13;
  localparam int FLD_LSB = IR_W - OPC_W - 3*REG_W;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
  } state_t;

  typedef struct packed {
    logic             en;
    logic [REG_W-1:0] sel;
  } reg_sel_t;

  state_t             state, state_nxt, after_last;
  reg_sel_t           rin, rout;
  logic [OPC_W-1:0]   opc;
  logic [REG_W-1:0]   ra, rb, rc;
  logic [NUM_OPS-1:0] op_dec;
  logic               legal, unary, muldiv;
  logic               unused_ir_bits;

  assign opc = ir[IR_W-1 -: OPC_W];
  assign ra  = ir[IR_W-1-OPC_W -: REG_W];
  assign rb  = ir[IR_W-1-OPC_W-REG_W -: REG_W];
  assign rc  = ir[IR_W-1-OPC_W-2*REG_W -: REG_W];
  assign unused_ir_bits = ^ir[FLD_LSB-1:0];

  assign legal  = opc < OPC_W'(NUM_OPS);
  assign unary  = (opc == OPC_W'(9)) || (opc == OPC_W'(10));
  assign muldiv = (opc == OPC_W'(11)) || (opc == OPC_W'(12));

  always_comb begin
    for (int i = 0; i < NUM_OPS; i++) op_dec[i] = (opc == OPC_W'(i));
  end

  // Chained instructions go straight to the next fetch with no idle bubble
  assign after_last = start ? S_T0 : S_IDLE;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rin       = '0;
    rout      = '0;
    alu_op    = '0;
    PCout     = 1'b0;
    PCin      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    MDRout    = 1'b0;
    Read      = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zin       = 1'b0;
    Zlowout   = 1'b0;
    Zhighout  = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0: begin
        PCout          = 1'b1;
        MARin          = 1'b1;
        alu_op[INC_PC] = 1'b1;
        Zin            = 1'b1;
        state_nxt      = S_T1;
      end
      // Held while memory stalls; reloading PC from an unchanged Z is harmless
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_nxt = S_T2;
      end
      S_T2: begin
        MDRout    = 1'b1;
        IRin      = 1'b1;
        state_nxt = S_T3;
      end
      S_T3: begin
        if (!legal) begin
          state_nxt = S_FAULT;
        end else begin
          rout = '{en: 1'b1, sel: rb};
          if (unary) begin
            alu_op[NUM_OPS-1:0] = op_dec;
            Zin                 = 1'b1;
          end else begin
            Yin = 1'b1;
          end
          state_nxt = S_T4;
        end
      end
      S_T4: begin
        if (unary) begin
          Zlowout   = 1'b1;
          rin       = '{en: 1'b1, sel: ra};
          done      = 1'b1;
          state_nxt = after_last;
        end else begin
          rout                = '{en: 1'b1, sel: rc};
          alu_op[NUM_OPS-1:0] = op_dec;
          Zin                 = 1'b1;
          state_nxt           = S_T5;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (muldiv) begin
          LOin      = 1'b1;
          state_nxt = S_T6;
        end else begin
          rin       = '{en: 1'b1, sel: ra};
          done      = 1'b1;
          state_nxt = after_last;
        end
      end
      S_T6: begin
        Zhighout  = 1'b1;
        HIin      = 1'b1;
        done      = 1'b1;
        state_nxt = after_last;
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    assign reg_in[g]  = rin.en  && (rin.sel  == REG_W'(g));
    assign reg_out[g] = rout.en && (rout.sel == REG_W'(g));
  end

  assign busy    = (state != S_IDLE) && (state != S_FAULT);
  assign illegal = (state == S_FAULT);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: stimulus pushes the expected per-cycle strobe sets of each instruction,
// a negedge monitor pops one per busy cycle and compares both a 16- and an 8-register DUT.
module tb_alu_op_sequencer;

  localparam int B_PCOUT = 12, B_PCIN = 11, B_MARIN = 10, B_MDRIN = 9, B_MDROUT = 8,
                 B_READ = 7, B_IRIN = 6, B_YIN = 5, B_ZIN = 4, B_ZLO = 3, B_ZHI = 2,
                 B_HIIN = 1, B_LOIN = 0;

  typedef struct packed {
    logic [12:0] sb;
    logic [13:0] op;
    logic        rin_v;
    logic [3:0]  rin;
    logic        rout_v;
    logic [3:0]  rout;
    logic        done;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir16, ir8;
  wire  [12:0] sb16, sb8;
  wire  [13:0] op16, op8;
  wire  [15:0] rin16, rout16;
  wire  [7:0]  rin8, rout8;
  wire         busy16, done16, ill16, busy8, done8, ill8;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clock = ~clock;

  alu_op_sequencer #(.NREGS(16), .IR_W(32), .OPC_W(5)) u16 (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir16),
    .reg_in(rin16), .reg_out(rout16), .alu_op(op16),
    .PCout(sb16[B_PCOUT]), .PCin(sb16[B_PCIN]), .MARin(sb16[B_MARIN]), .MDRin(sb16[B_MDRIN]),
    .MDRout(sb16[B_MDROUT]), .Read(sb16[B_READ]), .IRin(sb16[B_IRIN]), .Yin(sb16[B_YIN]),
    .Zin(sb16[B_ZIN]), .Zlowout(sb16[B_ZLO]), .Zhighout(sb16[B_ZHI]), .HIin(sb16[B_HIIN]),
    .LOin(sb16[B_LOIN]), .busy(busy16), .done(done16), .illegal(ill16));

  alu_op_sequencer #(.NREGS(8), .IR_W(32), .OPC_W(5)) u8 (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir8),
    .reg_in(rin8), .reg_out(rout8), .alu_op(op8),
    .PCout(sb8[B_PCOUT]), .PCin(sb8[B_PCIN]), .MARin(sb8[B_MARIN]), .MDRin(sb8[B_MDRIN]),
    .MDRout(sb8[B_MDROUT]), .Read(sb8[B_READ]), .IRin(sb8[B_IRIN]), .Yin(sb8[B_YIN]),
    .Zin(sb8[B_ZIN]), .Zlowout(sb8[B_ZLO]), .Zhighout(sb8[B_ZHI]), .HIin(sb8[B_HIIN]),
    .LOin(sb8[B_LOIN]), .busy(busy8), .done(done8), .illegal(ill8));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  function automatic logic [15:0] onehot(input logic v, input logic [3:0] idx, input int n);
    return v ? (16'(1) << (int'(idx) % n)) : 16'h0;
  endfunction

  function automatic logic [31:0] mk16(input logic [4:0] o, input logic [3:0] a, b, c,
                                       input logic [14:0] junk);
    return {o, a, b, c, junk};
  endfunction

  function automatic logic [31:0] mk8(input logic [4:0] o, input logic [3:0] a, b, c,
                                      input logic [17:0] junk);
    return {o, a[2:0], b[2:0], c[2:0], junk};
  endfunction

  // Reference: what each step of an instruction must show, from the instruction class
  task automatic push_model(input logic [4:0] opc, input logic [3:0] ra, rb, rc, input int nstall);
    exp_t e;
    bit   un, md;
    e = '0; e.sb[B_PCOUT] = 1; e.sb[B_MARIN] = 1; e.sb[B_ZIN] = 1; e.op[13] = 1; q.push_back(e);
    for (int k = 0; k <= nstall; k++) begin
      e = '0; e.sb[B_ZLO] = 1; e.sb[B_PCIN] = 1; e.sb[B_READ] = 1; e.sb[B_MDRIN] = 1;
      q.push_back(e);
    end
    e = '0; e.sb[B_MDROUT] = 1; e.sb[B_IRIN] = 1; q.push_back(e);
    if (opc > 12) begin
      e = '0; q.push_back(e);
      return;
    end
    un = (opc == 9) || (opc == 10);
    md = (opc == 11) || (opc == 12);
    e = '0; e.rout_v = 1; e.rout = rb;
    if (un) begin e.op[opc] = 1; e.sb[B_ZIN] = 1; end
    else e.sb[B_YIN] = 1;
    q.push_back(e);
    e = '0;
    if (un) begin e.sb[B_ZLO] = 1; e.rin_v = 1; e.rin = ra; e.done = 1; end
    else begin e.rout_v = 1; e.rout = rc; e.op[opc] = 1; e.sb[B_ZIN] = 1; end
    q.push_back(e);
    if (un) return;
    e = '0; e.sb[B_ZLO] = 1;
    if (md) e.sb[B_LOIN] = 1;
    else begin e.rin_v = 1; e.rin = ra; e.done = 1; end
    q.push_back(e);
    if (md) begin
      e = '0; e.sb[B_ZHI] = 1; e.sb[B_HIIN] = 1; e.done = 1; q.push_back(e);
    end
  endtask

  // Entered with start=1 ahead of the sampling edge; returns #1 into the last step
  task automatic issue(input logic [4:0] opc, input logic [3:0] ra, rb, rc,
                       input int nstall, input bit hold);
    int rem;
    push_model(opc, ra, rb, rc, nstall);
    @(posedge clock); #1;
    ir16 = mk16(opc, ra, rb, rc, 15'($urandom));
    ir8  = mk8(opc, ra, rb, rc, 18'($urandom));
    start = 1'b0;
    mem_ready = 1'($urandom);
    for (int k = 1; k <= nstall + 1; k++) begin
      @(posedge clock); #1;
      mem_ready = (k == nstall + 1);
    end
    rem = (opc > 12) ? 2 : ((opc == 9) || (opc == 10)) ? 3 : (opc >= 11) ? 5 : 4;
    for (int i = 0; i < rem; i++) begin
      @(posedge clock); #1;
      mem_ready = 1'($urandom);
    end
    start = hold;
  endtask

  always @(negedge clock) begin
    exp_t e;
    logic [15:0] x;
    if (clear) begin
      chk("busy_match", {15'h0, busy8}, {15'h0, busy16});
      if (busy16) begin
        if (q.size() == 0) begin
          chk("busy_without_expectation", {63'h0, busy16}, 64'h0);
        end else begin
          e = q.pop_front();
          chk("strobes16", sb16, e.sb);
          chk("alu_op16", op16, e.op);
          chk("reg_in16", rin16, onehot(e.rin_v, e.rin, 16));
          chk("reg_out16", rout16, onehot(e.rout_v, e.rout, 16));
          chk("done16", done16, e.done);
          chk("strobes8", sb8, e.sb);
          chk("alu_op8", op8, e.op);
          x = onehot(e.rin_v, e.rin, 8);
          chk("reg_in8", rin8, x);
          x = onehot(e.rout_v, e.rout, 8);
          chk("reg_out8", rout8, x);
          chk("done8", done8, e.done);
        end
      end else begin
        chk("idle_quiet16", {done16, rin16, rout16}, 64'h0);
        chk("idle_quiet8", {done8, rin8, rout8}, 64'h0);
      end
    end
  end

  task automatic chk_all_zero(input string nm);
    chk({nm, "16"}, {sb16, op16, rin16, rout16, busy16, done16, ill16}, 64'h0);
    chk({nm, "8"}, {sb8, op8, rin8, rout8, busy8, done8, ill8}, 64'h0);
  endtask

  initial begin
    bit hold;
    clear = 1'b0; start = 1'b0; mem_ready = 1'b1; ir16 = '0; ir8 = '0;
    #3 chk_all_zero("reset_outputs");
    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1 chk("idle_after_release", {busy16, busy8, ill16, ill8}, 64'h0);

    // AND R2 = R5 & R6, then MUL R3*R4, NEG R1 = -R7, AND with 3-cycle memory stall
    start = 1'b1; issue(5'd2, 4'd2, 4'd5, 4'd6, 0, 1'b0);
    repeat (2) @(posedge clock); #1 start = 1'b1;
    issue(5'd11, 4'd0, 4'd3, 4'd4, 0, 1'b0);
    repeat (2) @(posedge clock); #1 start = 1'b1;
    issue(5'd9, 4'd1, 4'd7, 4'd0, 0, 1'b0);
    repeat (2) @(posedge clock); #1 start = 1'b1;
    issue(5'd2, 4'd2, 4'd5, 4'd6, 3, 1'b0);
    repeat (2) @(posedge clock); #1 start = 1'b1;

    // Back-to-back chain with start held high
    issue(5'd0, 4'd1, 4'd2, 4'd3, 0, 1'b1);
    issue(5'd12, 4'd9, 4'd10, 4'd11, 1, 1'b1);
    issue(5'd10, 4'd15, 4'd14, 4'd0, 0, 1'b0);
    repeat (2) @(posedge clock); #1 start = 1'b1;

    for (int n = 0; n < 40; n++) begin
      hold = (n != 39) && ($urandom_range(0, 1) == 1);
      issue(5'($urandom_range(0, 12)), 4'($urandom), 4'($urandom), 4'($urandom),
            ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)), hold);
      if (!hold) begin
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1 start = (n != 39);
      end
    end
    repeat (2) @(posedge clock); #1;
    chk("queue_drained_random", q.size(), 0);

    // Reset in T4 of ADD
    start = 1'b1;
    push_model(5'd0, 4'd4, 4'd5, 4'd6, 0);
    @(posedge clock); #1;
    ir16 = mk16(5'd0, 4'd4, 4'd5, 4'd6, 15'h0); ir8 = mk8(5'd0, 4'd4, 4'd5, 4'd6, 18'h0);
    start = 1'b0; mem_ready = 1'b1;
    repeat (4) @(posedge clock); #1;
    clear = 1'b0;
    #1 chk_all_zero("reset_mid_instr");
    q.delete();
    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1 chk("idle_after_mid_reset", {busy16, busy8, done16, done8}, 64'h0);

    // Illegal opcode 15: trap, sticky against start, cleared only by reset
    start = 1'b1;
    issue(5'd15, 4'd0, 4'd0, 4'd0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      chk("fault16", {ill16, busy16}, 2'b10);
      chk("fault8", {ill8, busy8}, 2'b10);
    end
    clear = 1'b0;
    #1 chk_all_zero("reset_from_fault");
    start = 1'b0;
    @(posedge clock); #1 clear = 1'b1;
    @(posedge clock); #1 chk("idle_after_fault", {ill16, ill8, busy16, busy8}, 64'h0);

    start = 1'b1;
    issue(5'd7, 4'd3, 4'd8, 4'd9, 1, 1'b0);
    repeat (2) @(posedge clock); #1;
    chk("queue_drained_final", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
